// File: rtl/disp_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam int DIGIT_W = 4;

  // Bits needed to hold 0..v-1; never narrower than one bit.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/disp_image_buf.sv
// Double-buffered display image: shadow accepts updates, active image is
// swapped in only when the scan engine signals a commit opportunity.
module disp_image_buf import disp_pkg::*; #(
  parameter int DIGITS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        commit,
  input  logic                        upd_valid,
  input  logic [DIGIT_W*DIGITS-1:0]   upd_data,
  input  logic [DIGITS-1:0]           upd_point,
  input  logic [DIGITS-1:0]           upd_le,
  output logic                        upd_ready,
  output logic                        upd_done,
  output logic [DIGIT_W*DIGITS-1:0]   act_data,
  output logic [DIGITS-1:0]           act_point,
  output logic [DIGITS-1:0]           act_le
);

  logic [DIGIT_W*DIGITS-1:0] shd_data;
  logic [DIGITS-1:0]         shd_point;
  logic [DIGITS-1:0]         shd_le;
  logic                      pending;
  logic                      accept;

  assign upd_ready = ~pending;
  assign accept    = upd_valid & ~pending;

  // Accept needs pending=0 and commit needs pending=1, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_data  <= '0;
      shd_point <= '0;
      shd_le    <= '0;
      act_data  <= '0;
      act_point <= '0;
      act_le    <= '0;
      pending   <= 1'b0;
      upd_done  <= 1'b0;
    end else begin
      upd_done <= commit & pending;
      if (commit && pending) begin
        act_data  <= shd_data;
        act_point <= shd_point;
        act_le    <= shd_le;
        pending   <= 1'b0;
      end else if (accept) begin
        shd_data  <= upd_data;
        shd_point <= upd_point;
        shd_le    <= upd_le;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed scan of a common-anode seven-segment display with a blanking
// gap before each digit and frame-aligned image updates.
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int DIGITS    = 8,
  parameter int SHOW_CYC  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [DIGIT_W*DIGITS-1:0]      upd_data,
  input  logic [DIGITS-1:0]              upd_point,
  input  logic [DIGITS-1:0]              upd_le,
  output logic                           upd_done,
  output logic [DIGIT_W-1:0]             hex,
  output logic                           point,
  output logic                           le,
  output logic [DIGITS-1:0]              an,
  output logic [clog2(DIGITS)-1:0]       digit_idx,
  output logic                           frame_tick
);

  localparam int IDX_W = clog2(DIGITS);
  localparam int CNT_W = clog2((SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC);

  scan_state_t               state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      tick_q, tick_d;
  logic                      run_q;
  logic                      boundary;
  logic                      commit;
  logic [DIGIT_W*DIGITS-1:0] act_data;
  logic [DIGITS-1:0]         act_point;
  logic [DIGITS-1:0]         act_le;

  // run_q remembers the previous en so a re-enable restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BLANK;
      count_q <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      run_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      run_q   <= en;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    tick_d   = 1'b0;
    boundary = 1'b0;
    if (!en || !run_q) begin
      state_d = BLANK;
      count_d = '0;
      idx_d   = '0;
      tick_d  = en;
    end else begin
      case (state_q)
        BLANK: begin
          if (count_q == CNT_W'(BLANK_CYC - 1)) begin
            state_d = SHOW;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (count_q == CNT_W'(SHOW_CYC - 1)) begin
            state_d = BLANK;
            count_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
              idx_d    = '0;
              tick_d   = 1'b1;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = BLANK;
          count_d = '0;
        end
      endcase
    end
  end

  // Disabling flushes any pending image straight away.
  assign commit = boundary | ~en;

  disp_image_buf #(.DIGITS(DIGITS)) u_image_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .commit    (commit),
    .upd_valid (upd_valid),
    .upd_data  (upd_data),
    .upd_point (upd_point),
    .upd_le    (upd_le),
    .upd_ready (upd_ready),
    .upd_done  (upd_done),
    .act_data  (act_data),
    .act_point (act_point),
    .act_le    (act_le)
  );

  always_comb begin
    hex   = act_data[int'(idx_q) * DIGIT_W +: DIGIT_W];
    point = act_point[idx_q];
    le    = (state_q == SHOW) && act_le[idx_q];
    for (int i = 0; i < DIGITS; i++) begin
      an[i] = !((state_q == SHOW) && (idx_q == IDX_W'(i)));
    end
  end

  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: frame-position reference model plus directed pins.
module tb_disp_scan_ctrl;

  localparam int D     = 8;
  localparam int S     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + S;
  localparam int FRAME = D * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [31:0] upd_data = '0;
  logic [7:0]  upd_point = '0;
  logic [7:0]  upd_le = '0;
  logic        upd_done;
  logic [3:0]  hex;
  logic        point;
  logic        le;
  logic [7:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int checks = 0;
  int passes = 0;
  int k = 0;

  disp_scan_ctrl #(.DIGITS(D), .SHOW_CYC(S), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_data   (upd_data),
    .upd_point  (upd_point),
    .upd_le     (upd_le),
    .upd_done   (upd_done),
    .hex        (hex),
    .point      (point),
    .le         (le),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at t=%0t k=%0d: got %h expected %h", name, $time, k, act, exp);
  endtask

  // Model: frame position counter, image pair and pending flag.
  int          pos;
  bit          idle, m_tick, m_done, m_pend, m_commit, m_accept;
  logic [31:0] sh_d, ac_d;
  logic [7:0]  sh_p, ac_p, sh_l, ac_l;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0; idle = 0; m_tick = 0; m_done = 0; m_pend = 0;
      sh_d = '0; ac_d = '0; sh_p = '0; ac_p = '0; sh_l = '0; ac_l = '0;
    end else begin
      m_commit = m_pend && (!en || pos == FRAME - 1);
      m_accept = upd_valid && !m_pend;
      m_done   = m_commit;
      if (m_commit) begin
        ac_d = sh_d; ac_p = sh_p; ac_l = sh_l; m_pend = 0;
      end
      if (m_accept) begin
        sh_d = upd_data; sh_p = upd_point; sh_l = upd_le; m_pend = 1;
      end
      if (!en) begin
        pos = 0; idle = 1; m_tick = 0;
      end else if (idle) begin
        pos = 0; idle = 0; m_tick = 1;
      end else begin
        m_tick = (pos == FRAME - 1);
        pos = (pos + 1) % FRAME;
      end
    end
  end

  int         c_slot;
  bit         c_lit;
  logic [7:0] c_an;

  always @(negedge clk) begin
    if (rst_n) begin
      c_slot = pos / SLOT;
      c_lit  = !idle && (pos % SLOT) >= B;
      c_an   = 8'hFF;
      if (c_lit) c_an[c_slot] = 1'b0;
      check("an", 32'(an), 32'(c_an));
      check("le", 32'(le), 32'(c_lit && ac_l[c_slot]));
      check("hex", 32'(hex), 32'((ac_d >> (4 * c_slot)) & 32'hF));
      check("point", 32'(point), 32'(ac_p[c_slot]));
      check("digit_idx", 32'(digit_idx), 32'(c_slot));
      check("frame_tick", 32'(frame_tick), 32'(m_tick));
      check("upd_done", 32'(upd_done), 32'(m_done));
      check("upd_ready", 32'(upd_ready), 32'(!m_pend));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    k += n;
  endtask

  task automatic offer(input logic [31:0] d, input logic [7:0] p, input logic [7:0] l);
    upd_data = d; upd_point = p; upd_le = l; upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
  endtask

  initial begin
    #7;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_le", 32'(le), 0);
    check("rst_hex", 32'(hex), 0);
    check("rst_ready", 32'(upd_ready), 1);
    check("rst_idx", 32'(digit_idx), 0);
    check("rst_tick", 32'(frame_tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // Free-running scan, dark image.
    step(2);  check("s1_an_d0", 32'(an), 32'hFE);
    step(42); check("s1_an_d7", 32'(an), 32'h7F);
    check("s1_idx_d7", 32'(digit_idx), 7);
    check("s1_le_dark", 32'(le), 0);
    step(4);  check("s1_tick48", 32'(frame_tick), 1);
    check("s1_an_blank", 32'(an), 32'hFF);

    // Image A mid-frame; B offered while pending and dropped.
    step(10);
    offer(32'h89ABCDEF, 8'h01, 8'hFF);
    check("s2_ready_low", 32'(upd_ready), 0);
    step(70 - k);
    offer(32'hDEADBEEF, 8'hFF, 8'h00);
    step(96 - k);
    check("s2_done", 32'(upd_done), 1);
    check("s2_tick", 32'(frame_tick), 1);
    step(2);
    check("s2_hex_d0", 32'(hex), 4'hF);
    check("s2_point_d0", 32'(point), 1);
    check("s2_le_d0", 32'(le), 1);
    step(6);
    check("s2_hex_d1", 32'(hex), 4'hE);
    check("s2_point_d1", 32'(point), 0);
    offer(32'h12345678, 8'h00, 8'hFF);
    step(146 - k);
    check("s3_hex_d0", 32'(hex), 4'h8);

    // Transfer on the boundary edge itself commits a frame later.
    step(191 - k);
    offer(32'hCAFEF00D, 8'hF0, 8'h0F);
    check("s4_tick", 32'(frame_tick), 1);
    check("s4_no_done", 32'(upd_done), 0);
    check("s4_pending", 32'(upd_ready), 0);
    step(240 - k);
    check("s4_done_late", 32'(upd_done), 1);
    step(2);
    check("s4_hex_d0", 32'(hex), 4'hD);

    // Disable mid-SHOW of digit 5 with an image pending.
    step(250 - k);
    offer(32'h55AA33CC, 8'h00, 8'hFF);
    step(273 - k);
    check("s5_an_d5", 32'(an), 32'hDF);
    en = 1'b0;
    step(1);
    check("s5_an_off", 32'(an), 32'hFF);
    check("s5_le_off", 32'(le), 0);
    check("s5_done", 32'(upd_done), 1);
    step(4);
    en = 1'b1;
    step(1);
    check("s5_tick", 32'(frame_tick), 1);
    check("s5_blank0", 32'(an), 32'hFF);
    step(1);
    check("s5_blank1", 32'(an), 32'hFF);
    step(1);
    check("s5_an_d0", 32'(an), 32'hFE);
    check("s5_hex_d0", 32'(hex), 4'hC);

    // Random traffic with occasional enable drops.
    for (int i = 0; i < 400; i++) begin
      upd_valid = ($urandom_range(0, 3) == 0);
      upd_data  = $urandom;
      upd_point = 8'($urandom);
      upd_le    = 8'($urandom);
      en        = ($urandom_range(0, 39) != 0);
      step(1);
    end
    upd_valid = 1'b0;
    en = 1'b1;
    step(3);

    // Asynchronous reset mid-SHOW with an image pending.
    en = 1'b0;
    step(2);
    en = 1'b1;
    step(1);
    offer(32'h0F0F0F0F, 8'hFF, 8'hFF);
    check("s6_pending", 32'(upd_ready), 0);
    step(2);
    check("s6_showing", 32'(an), 32'hFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_an_rst", 32'(an), 32'hFF);
    check("s6_le_rst", 32'(le), 0);
    check("s6_ready_rst", 32'(upd_ready), 1);
    check("s6_hex_rst", 32'(hex), 0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    step(2);
    check("s6_an_after", 32'(an), 32'hFE);
    check("s6_le_dark", 32'(le), 0);
    check("s6_ready_after", 32'(upd_ready), 1);
    step(60);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for an 8-digit common-anode seven-segment display.
- Sits directly upstream of the per-digit hex-to-segment decoder. Each digit slot drives that decoder's D3..D0, point and LE inputs, plus the active-low anode selects.
- Holds a double-buffered display image. New images are accepted through a valid/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new data.
- Inserts a blanking gap between digits to suppress ghosting.

Parameters:
- DIGITS, 8: number of digits scanned; must be >= 2.
- SHOW_CYC, 100000: clock cycles each digit is lit; must be >= 1.
- BLANK_CYC, 1000: clock cycles of all-dark gap before each digit; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; 0 forces the display dark.
- upd_valid  in  1  new image offered.
- upd_ready  out  1  controller can accept an image (no update pending).
- upd_data  in  4*DIGITS  hex nibbles; digit i = upd_data[4i+3:4i].
- upd_point  in  DIGITS  per-digit point bit, passed unmodified to the decoder's point input.
- upd_le  in  DIGITS  per-digit LE; 0 blanks that digit.
- upd_done  out  1  one-cycle pulse when a pending image is committed.
- hex  out  4  D3..D0 to the decoder.
- point  out  1  to the decoder's point input.
- le  out  1  to the decoder's LE input.
- an  out  DIGITS  anode selects, active-low, one-hot-low while a digit is shown.
- digit_idx  out  clog2(DIGITS)  index of the current digit slot.
- frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Output decode:
  - All outputs are combinational decodes of registered state only; there is no input-to-output path except upd_ready = ~pending.
- Reset (async, rst_n=0):
  - state=BLANK, digit_idx=0, count=0.
  - Active image: data=0, point=0, le=0 (dark). Shadow image cleared.
  - pending=0, upd_done=0, frame_tick=0, an=all 1s, le=0, hex=0, point=0.
- FSM states: BLANK, SHOW. count runs 0..N-1 within each state.
  - BLANK:
    - an=all 1s, le=0, hex and point = active values for digit_idx.
    - Lasts BLANK_CYC cycles, then goes to SHOW with count=0.
  - SHOW:
    - an[digit_idx]=0, all other anodes 1.
    - hex=active_data[digit_idx], point=active_point[digit_idx], le=active_le[digit_idx].
    - Lasts SHOW_CYC cycles, then goes to BLANK.
    - On that exit, digit_idx increments, wrapping from DIGITS-1 to 0.
  - Frame length = DIGITS*(BLANK_CYC+SHOW_CYC) cycles.
- Frame boundary (SHOW with digit_idx=DIGITS-1 exiting to BLANK with digit_idx=0):
  - frame_tick pulses high for the first cycle of the new BLANK.
  - If pending=1 on the boundary edge: active image <= shadow, pending <= 0, and upd_done is high for that same first cycle.
- Handshake:
  - A transfer occurs when upd_valid & upd_ready on a rising edge: shadow <= upd_data/upd_point/upd_le, pending <= 1.
  - upd_ready is low while pending=1; upd_valid is ignored then.
  - Transfer and frame boundary on the same edge: transfer loads the shadow, but commit uses the pre-edge pending (0), so the new image commits at the next boundary.
  - Transfer presented the cycle after a commit is accepted (ready=1 again).
- Enable:
  - While en=0: state forced to BLANK, digit_idx=0, count=0, frame_tick=0, an=all 1s, le=0.
  - While en=0, the handshake stays live. A pending image commits on the next edge with upd_done pulsing; an accept and commit never happen on the same edge.
  - When en returns to 1: a full BLANK of digit 0 starts with count=0, and frame_tick pulses in its first cycle.
- Reset mid-operation: immediate return to the reset values; any shadow or pending image is discarded.
- Width rules:
  - count width = clog2(max(SHOW_CYC, BLANK_CYC)).
  - digit_idx wraps explicitly at DIGITS-1 (DIGITS need not be a power of 2).

Decomposition:
- Shared package disp_pkg:
  - scan state enum (BLANK, SHOW).
  - DIGIT_W = 4 constant.
  - a clog2 helper function.
- One sub-module, disp_image_buf: shadow/active registers, pending flag, handshake and commit. The FSM/counter stays in disp_scan_ctrl.

Test Plan:
All scenarios use DIGITS=8, SHOW_CYC=4, BLANK_CYC=2, giving a 48-cycle frame.
1. Reset then en=1, no update -> an is never low except when active_le=0, le=0 throughout; frame_tick every 48 cycles; digit_idx sequence 0..7; SHOW an pattern 8'hFE, FD, ..., 7F.
2. Offer upd_data=32'h89ABCDEF, upd_le=8'hFF, upd_point=8'h01 mid-frame -> upd_ready falls the next cycle. At the next boundary: upd_done and frame_tick pulse together. The next frame's SHOW slots give hex F,E,D,C,B,A,9,8, point=1 only on digit 0, le=1.
3. Offer a second image while pending -> upd_ready=0 and the image is ignored; after commit, re-offer 32'h12345678 -> accepted and shown the following frame.
4. Handshake exactly on the boundary edge with pending=0 -> upd_done stays 0 at that boundary; commit and upd_done occur one frame (48 cycles) later.
5. en=0 mid-SHOW of digit 5 with pending=1 -> next cycle: an=8'hFF, le=0, upd_done pulses. en=1 -> digit 0 BLANK for 2 cycles, frame_tick pulses, then new data shown.
6. Assert rst_n=0 asynchronously mid-SHOW with pending=1 -> an=8'hFF, le=0 immediately; after release, the display stays dark (active_le=0) and upd_ready=1.
